// File: rtl/unsolved_copy_scheduler.sv
// -----------------------------------------------------------------------------
// unsolved_copy_scheduler
//
// Collects unsolved copy tokens from the result-RAM blocks and re-issues them,
// one per cycle, as copy read commands toward the owning block.
//
// The blocks emit tokens without backpressure, so every block owns a small
// private FIFO. A round-robin arbiter picks one non-empty FIFO and loads the
// single output register whenever that register is empty or being consumed.
// page_finish flushes all state and opens the RAM clean window, which lasts
// CLEAN_CYCLES cycles. flush_busy is high for the whole window.
//
// Ports
//   clk                clock
//   rst_n              synchronous, active-low reset
//   page_finish        end of file: flush everything, start the clean window
//   unsolved_valid_in  per-block token strobe
//   unsolved_token_in  block i at [33i+32:33i] = {addr[8:0], miss[7:0], offset[15:0]}
//   out_ready          consumer accepts out_* this cycle
//   out_valid          re-issue command valid
//   out_block          index of the FIFO (block) that produced the token
//   out_address        copy address
//   out_valid_mask     bytes still missing
//   out_offset         copy offset
//   pending_cnt        tokens held in the FIFOs plus the output register
//   all_empty          pending_cnt == 0 and no clean window active
//                      (so it reads 1 straight after reset)
//   flush_busy         flush / clean window active
//   overflow_err       sticky per block: a token was dropped on a full FIFO
// -----------------------------------------------------------------------------
module unsolved_copy_scheduler #(
  parameter int NUM_BLOCKS   = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLEAN_CYCLES = 512,
  parameter int PCNT_W       = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     page_finish,
  input  logic [NUM_BLOCKS-1:0]    unsolved_valid_in,
  input  logic [NUM_BLOCKS*33-1:0] unsolved_token_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [3:0]               out_block,
  output logic [8:0]               out_address,
  output logic [7:0]               out_valid_mask,
  output logic [15:0]              out_offset,
  output logic [PCNT_W-1:0]        pending_cnt,
  output logic                     all_empty,
  output logic                     flush_busy,
  output logic [NUM_BLOCKS-1:0]    overflow_err
);

  localparam int TOK_W = 33;
  localparam int BID_W = 4;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FC_W  = (CLEAN_CYCLES > 1) ? $clog2(CLEAN_CYCLES) : 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;

  logic                run_active;
  logic [TOK_W-1:0]    fifo_head [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] fifo_nempty;
  logic [NUM_BLOCKS-1:0] push_ok;
  logic [NUM_BLOCKS-1:0] ovf_set;
  logic [NUM_BLOCKS-1:0] pop_sel;

  logic [BID_W-1:0]    rr_q;
  logic [BID_W-1:0]    grant_idx;
  logic [BID_W-1:0]    cand;
  logic                grant_any;
  logic                load_en;

  logic                out_valid_q;
  logic [BID_W-1:0]    out_block_q;
  logic [TOK_W-1:0]    out_tok_q;

  logic [PCNT_W-1:0]   pending_q, pending_d;
  logic [PCNT_W-1:0]   push_cnt;
  logic [NUM_BLOCKS-1:0] overflow_q;

  // Flush has priority over everything else in the cycle it is sampled.
  assign run_active = (state_q == ST_RUN) && !page_finish;

  // ---------------------------------------------------------------------------
  // State machine: RUN / FLUSH with clean-window counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (page_finish) begin
      // Entering the window, or restarting it when already flushing.
      state_d     = ST_FLUSH;
      flush_cnt_d = '0;
    end else if (state_q == ST_FLUSH) begin
      if (flush_cnt_q == FC_W'(CLEAN_CYCLES - 1)) begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
      end else begin
        flush_cnt_d = flush_cnt_q + FC_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-block FIFOs
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_fifo
      logic [TOK_W-1:0] mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0] wr_ptr_q;
      logic [PTR_W-1:0] rd_ptr_q;
      logic [CNT_W-1:0] cnt_q;
      logic             full;
      logic             push_req;

      assign full            = (cnt_q == CNT_W'(FIFO_DEPTH));
      assign push_req        = run_active & unsolved_valid_in[gi];
      // A full FIFO still accepts when it is popped on the same edge.
      assign push_ok[gi]     = push_req & (~full | pop_sel[gi]);
      assign ovf_set[gi]     = push_req & full & ~pop_sel[gi];
      assign fifo_nempty[gi] = (cnt_q != '0);
      assign fifo_head[gi]   = mem_q[rd_ptr_q];

      always_ff @(posedge clk) begin
        if (!rst_n || page_finish) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          if (push_ok[gi]) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
          if (pop_sel[gi]) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
          cnt_q <= cnt_q + CNT_W'(push_ok[gi]) - CNT_W'(pop_sel[gi]);
        end
      end

      // Storage needs no reset: the pointers define what is valid.
      always_ff @(posedge clk) begin
        if (push_ok[gi]) begin
          mem_q[wr_ptr_q] <= unsolved_token_in[gi*TOK_W +: TOK_W];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first non-empty FIFO after rr_q, wrapping.
  // Scanning from the farthest offset down lets the nearest one win.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_BLOCKS; k >= 1; k--) begin
      cand = rr_q + BID_W'(k);
      if (fifo_nempty[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign load_en = run_active & grant_any & (~out_valid_q | out_ready);
  assign pop_sel = load_en ? (NUM_BLOCKS'(1) << grant_idx) : '0;

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n || page_finish) begin
      out_valid_q <= 1'b0;
      out_block_q <= '0;
      out_tok_q   <= '0;
      rr_q        <= BID_W'(NUM_BLOCKS - 1);
    end else if (load_en) begin
      out_valid_q <= 1'b1;
      out_block_q <= grant_idx;
      out_tok_q   <= fifo_head[grant_idx];
      rr_q        <= grant_idx;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending count and sticky overflow flags
  // ---------------------------------------------------------------------------
  always_comb begin
    push_cnt = '0;
    for (int k = 0; k < NUM_BLOCKS; k++) begin
      push_cnt = push_cnt + PCNT_W'(push_ok[k]);
    end
    // Moving a token from a FIFO into the output register is count-neutral.
    pending_d = pending_q + push_cnt - PCNT_W'(out_valid_q & out_ready & run_active);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || page_finish) begin
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_q | ovf_set;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid      = out_valid_q;
  assign out_block      = out_block_q;
  assign out_address    = out_tok_q[32:24];
  assign out_valid_mask = out_tok_q[23:16];
  assign out_offset     = out_tok_q[15:0];
  assign pending_cnt    = pending_q;
  assign flush_busy     = (state_q == ST_FLUSH);
  assign all_empty      = (pending_q == '0) && (state_q == ST_RUN);
  assign overflow_err   = overflow_q;

endmodule
